myregfile_bb: RTL and testbench

MYREGFILE_BB -- requirements
Module: myregfile_bb

---
 rtl/myregfile_pkg.sv | 24 ++
 rtl/myregfile_bank.sv | 47 ++++
 rtl/myregfile_bb.sv | 127 ++++++++++++
 tb/tb_myregfile_bb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myregfile_pkg.sv
// Shared definitions for the myregfile register-file slice.
//   - FSM state encoding for the read-response sequencer (IDLE/WAIT/RESP)
//   - Legal ranges for the DEPTH and RD_LAT parameters
//   - Address-width helper used to derive ADDR_W from DEPTH
package myregfile_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 256;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

  // The latency counter only ever holds RD_LAT-1, so 3 bits reach 7.
  localparam int CNT_W = 3;

  // clog2(depth) with a floor of 1 so a 2-entry file still has an address bit.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/myregfile_bank.sv
// DEPTH x DATA_W register array, byte-masked write port and combinational
// read port. Out-of-range addresses (>= DEPTH) write nothing and read zero.
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset (clears all)
//   wr_en/wr_addr/wr_data/wr_mask : one write per cycle, wr_mask bit b -> byte b
//   rd_addr/rd_data       : combinational read
module myregfile_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_mask,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] regs [DEPTH];

  // Address decode by comparison against each legal index: an address at or
  // beyond DEPTH matches no entry, which gives the no-write / zero-read rule.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_mask[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

endmodule

// File: rtl/myregfile_bb.sv
// Register file with a sticky arm, single-outstanding read sequencer and a
// fixed RD_LAT read latency.
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset
//   enable         : arm request, latched sticky until reset
//   req_*          : request channel (write when req_wren=1, else read)
//   resp_*         : read response channel, resp_err flags addr >= DEPTH
//   dbg_state      : current sequencer state (ST_* from myregfile_pkg)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The source holds valid and payload until that edge; ready may be
// low at any time and never depends combinationally on valid.
module myregfile_bb
  import myregfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 2,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wren,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic [1:0]          dbg_state
);

  logic              armed;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_err;
  logic [ADDR_W-1:0] bank_raddr;
  logic [DATA_W-1:0] bank_rdata;
  logic              wr_fire;
  logic              rd_fire;
  logic              req_oor;

  assign req_ready  = armed && (state == ST_IDLE);
  assign wr_fire    = req_valid && req_ready && req_wren;
  assign rd_fire    = req_valid && req_ready && !req_wren;
  assign req_oor    = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH);
  assign resp_valid = (state == ST_RESP);
  assign dbg_state  = state;

  // While idle the bank is addressed by the live request so an RD_LAT=1 read
  // can sample on its accept edge; otherwise by the captured read address.
  assign bank_raddr = (state == ST_IDLE) ? req_addr : rd_addr;

  myregfile_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_fire),
    .wr_addr (req_addr),
    .wr_data (req_wdata),
    .wr_mask (req_wmask),
    .rd_addr (bank_raddr),
    .rd_data (bank_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (enable) begin
      armed <= 1'b1;
    end
  end

  // Response data is captured as RESP is entered. No write can be accepted
  // outside IDLE, so this equals the register content at accept time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rd_addr   <= '0;
      rd_err    <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_fire) begin
            rd_addr <= req_addr;
            rd_err  <= req_oor;
            cnt     <= CNT_W'(RD_LAT - 1);
            if (RD_LAT == 1) begin
              state     <= ST_RESP;
              resp_data <= req_oor ? '0 : bank_rdata;
              resp_err  <= req_oor;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Counter reaches zero on the same edge that enters RESP.
          if (cnt <= CNT_W'(1)) begin
            cnt       <= '0;
            state     <= ST_RESP;
            resp_data <= rd_err ? '0 : bank_rdata;
            resp_err  <= rd_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myregfile_bb.sv
module tb_myregfile_bb;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT A: DATA_W=64, DEPTH=6, RD_LAT=2 ----------------
  localparam int A_DEPTH = 6;
  logic        enable, req_valid, req_ready, req_wren;
  logic [2:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;
  logic [1:0]  dbg_state;

  myregfile_bb #(.DATA_W(64), .DEPTH(A_DEPTH), .RD_LAT(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .dbg_state(dbg_state)
  );

  // ---------------- DUT B: DATA_W=32, DEPTH=8, RD_LAT=1 ----------------
  logic        enable_b, req_valid_b, req_ready_b, req_wren_b;
  logic [2:0]  req_addr_b;
  logic [31:0] req_wdata_b;
  logic [3:0]  req_wmask_b;
  logic        resp_valid_b, resp_err_b;
  logic        resp_ready_b = 1'b1;
  logic [31:0] resp_data_b;
  logic [1:0]  dbg_state_b;

  myregfile_bb #(.DATA_W(32), .DEPTH(8), .RD_LAT(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wren(req_wren_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wmask(req_wmask_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_data(resp_data_b),
    .resp_err(resp_err_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];          // {err, data} expected per accepted read
  logic [63:0] model_regs [8];
  logic [31:0] model_b [8];
  logic [31:0] exp_b[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_write(input logic [2:0] addr, input logic [63:0] data,
                                      input logic [7:0] mask);
    if (int'(addr) < A_DEPTH)
      for (int b = 0; b < 8; b++)
        if (mask[b]) model_regs[addr][8*b +: 8] = data[8*b +: 8];
  endfunction

  function automatic logic [64:0] model_read(input logic [2:0] addr);
    if (int'(addr) >= A_DEPTH) return {1'b1, 64'h0};
    return {1'b0, model_regs[addr]};
  endfunction

  // Every completed response handshake is compared against the model queue.
  always @(negedge clock) begin
    #1;
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0h required=none", {resp_err, resp_data});
      end else begin
        check("sb_resp", 128'({resp_err, resp_data}), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    enable = 0; req_valid = 0; req_wren = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b1;
    enable_b = 0; req_valid_b = 0; req_wren_b = 0; req_addr_b = '0; req_wdata_b = '0;
    req_wmask_b = '0;
    exp_q.delete();
    exp_b.delete();
    for (int i = 0; i < 8; i++) begin model_regs[i] = '0; model_b[i] = '0; end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_data", 128'(resp_data), 128'(0));
    check("rst_resp_err", 128'(resp_err), 128'(0));
    check("rst_state_idle", 128'(dbg_state), 128'(0));
    reset_n = 1'b1;
  endtask

  task automatic arm();
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    check("armed_ready", 128'(req_ready), 128'(1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    check("req_ready_wait", 128'(req_ready), 128'(1));
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [63:0] data, input logic [7:0] mask);
    req_valid = 1'b1; req_wren = 1'b1; req_addr = addr; req_wdata = data; req_wmask = mask;
    wait_ready();
    @(posedge clock);
    model_write(addr, data, mask);
    @(negedge clock);
    req_valid = 1'b0; req_wren = 1'b0;
  endtask

  task automatic rd_issue(input logic [2:0] addr);
    req_valid = 1'b1; req_wren = 1'b0; req_addr = addr;
    wait_ready();
    exp_q.push_back(model_read(addr));
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // lat counts negedges after the accept edge until resp_valid is seen.
  task automatic wait_resp(output logic [63:0] d, output logic e, output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clock); lat++; end
    check("resp_seen", 128'(resp_valid), 128'(1));
    d = resp_data;
    e = resp_err;
  endtask

  task automatic do_read(input logic [2:0] addr, output logic [63:0] d, output logic e);
    int lat;
    rd_issue(addr);
    wait_resp(d, e, lat);
    check("rd_latency", 128'(lat), 128'(2));
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wren;
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;
    int          n_acc, n_resp, cyc, last_acc;

    vecs[0]  = '{1'b1, 3'd3, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 3'd3, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[3]  = '{1'b1, 3'd7, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 3'd7, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[5]  = '{1'b1, 3'd0, 64'hFFEEDDCCBBAA9988, 8'h81, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 64'h0, 8'h00, 64'hFF00000000000088, 1'b0};
    vecs[7]  = '{1'b1, 3'd5, 64'h5555555555555555, 8'hF0, 64'h0, 1'b0};
    vecs[8]  = '{1'b0, 3'd5, 64'h0, 8'h00, 64'h5555555500000000, 1'b0};
    vecs[9]  = '{1'b0, 3'd6, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 3'd1, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 3'd2, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[12] = '{1'b0, 3'd4, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[13] = '{1'b0, 3'd3, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    vecs[14] = '{1'b0, 3'd7, 64'h0, 8'h00, 64'h0, 1'b1};

    do_reset();

    // Arming: a pending read must wait, then be taken once armed.
    req_valid = 1'b1; req_wren = 1'b0; req_addr = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("unarmed_ready", 128'(req_ready), 128'(0));
    end
    arm();
    rd_issue(3'd1);
    wait_resp(d, e, lat);
    check("arm_rd_latency", 128'(lat), 128'(2));
    @(posedge clock);
    @(negedge clock);

    // Table-driven masked writes, out-of-range accesses and read-after-write.
    foreach (vecs[i]) begin
      if (vecs[i].wren) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
      end else begin
        do_read(vecs[i].addr, d, e);
        check("vec_data", 128'(d), 128'(vecs[i].exp_data));
        check("vec_err", 128'(e), 128'(vecs[i].exp_err));
      end
    end

    // Backpressure: response held while resp_ready is low.
    resp_ready = 1'b0;
    rd_issue(3'd3);
    wait_resp(d, e, lat);
    check("bp_latency", 128'(lat), 128'(2));
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 128'(resp_valid), 128'(1));
      check("bp_data", 128'(resp_data), 128'(64'h11223344AAAAAAAA));
      check("bp_req_ready", 128'(req_ready), 128'(0));
      @(negedge clock);
    end
    resp_ready = 1'b1;
    check("hs_req_ready", 128'(req_ready), 128'(0));
    @(posedge clock);
    @(negedge clock);
    check("bp_idle", 128'(dbg_state), 128'(0));
    check("bp_ready_after", 128'(req_ready), 128'(1));
    check("bp_valid_after", 128'(resp_valid), 128'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(3'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      else
        do_read(3'($urandom_range(0, 7)), d, e);
    end

    // Reset one cycle after a read accept: the read must vanish.
    do_write(3'd2, 64'hCAFEF00D12345678, 8'hFF);
    rd_issue(3'd2);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("post_rst_no_resp", 128'(resp_valid), 128'(0));
      check("post_rst_unarmed", 128'(req_ready), 128'(0));
    end
    arm();
    for (int a = 0; a < A_DEPTH; a++) begin
      do_read(3'(a), d, e);
      check("post_rst_reg_zero", 128'(d), 128'(0));
    end
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    // RD_LAT=1 instance: back-to-back reads with resp_ready tied high.
    enable_b = 1'b1;
    @(negedge clock);
    enable_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid_b = 1'b1; req_wren_b = 1'b1; req_addr_b = 3'(i);
      req_wdata_b = $urandom; req_wmask_b = 4'hF;
      check("b_wr_ready", 128'(req_ready_b), 128'(1));
      @(posedge clock);
      model_b[i] = req_wdata_b;
      @(negedge clock);
    end
    req_valid_b = 1'b1; req_wren_b = 1'b0; req_addr_b = 3'd0;
    n_acc = 0; n_resp = 0; cyc = 0; last_acc = -10;
    while (n_resp < 8 && cyc < 100) begin
      if (req_valid_b && req_ready_b) begin
        if (n_acc > 0) check("b_accept_spacing", 128'(cyc - last_acc), 128'(2));
        last_acc = cyc;
        exp_b.push_back(model_b[req_addr_b]);
        n_acc++;
      end
      @(negedge clock);
      cyc++;
      if (resp_valid_b) begin
        check("b_resp_lat", 128'(cyc - last_acc), 128'(1));
        if (exp_b.size() == 0) check("b_unexpected_resp", 128'(1), 128'(0));
        else check("b_data", 128'(resp_data_b), 128'(exp_b.pop_front()));
        check("b_err", 128'(resp_err_b), 128'(0));
        check("b_ready_in_hs", 128'(req_ready_b), 128'(0));
        n_resp++;
        req_addr_b = req_addr_b + 3'd1;
        if (n_acc == 8) req_valid_b = 1'b0;
      end
    end
    check("b_resp_count", 128'(n_resp), 128'(8));
    @(negedge clock);
    check("b_final_idle", 128'(dbg_state_b), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
